byte_stripping_2f: RTL

// - Upstream neighbour of the byte-unstriping stage: splits one byte stream at 2f rate into two byte lanes (stripe 0/1).
// - Single clock clk_2f. Lanes update only on clk_f-equivalent publish edges (every 2nd cycle), lane pair always aligned.
// - An unpaired byte is flushed alone after an idle timeout; stripe 1 is marked invalid in that case.

---
 rtl/byte_stripping_2f.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/byte_stripping_2f.sv
// byte_stripping_2f
// Splits a single byte stream running at the 2f rate into two aligned byte
// lanes (stripe 0 = even-position bytes, stripe 1 = odd-position bytes).
// The lanes change only on every second clk_2f edge (the clk_f-equivalent
// publish edge). A pair that completes between publish edges waits in a
// one-deep pending register. A lone byte is flushed as a half pair, with
// stripe 1 marked invalid, after FLUSH_TIMEOUT idle cycles.
//
// Collection states:
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_EMPTY | lane_ptr = 0, no byte held; the next valid byte goes to hold0
//   ST_HALF  | lane_ptr = 1, hold0 occupied; waiting for the partner byte
//            | or for the idle flush
module byte_stripping_2f #(
  parameter int DATA_WIDTH    = 8,
  parameter int FLUSH_TIMEOUT = 4
) (
  input  logic                  clk_2f,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] data_stripe_0,
  output logic [DATA_WIDTH-1:0] data_stripe_1,
  output logic                  valid_stripe_0,
  output logic                  valid_stripe_1,
  output logic                  phase_f,
  output logic                  overflow_err
);

  localparam int CNT_W = $clog2(FLUSH_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(FLUSH_TIMEOUT - 1);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HALF  = 1'b1
  } lane_state_t;

  lane_state_t           r_state;
  lane_state_t           w_state_nxt;
  logic [DATA_WIDTH-1:0] r_hold0;
  logic [DATA_WIDTH-1:0] w_hold0_nxt;
  logic [CNT_W-1:0]      r_idle_cnt;
  logic [CNT_W-1:0]      w_idle_cnt_nxt;

  // Pair produced by the collector on the current edge.
  logic                  w_pair_done;
  logic [DATA_WIDTH-1:0] w_pair_d0;
  logic [DATA_WIDTH-1:0] w_pair_d1;
  logic                  w_pair_v1;

  // One-deep pending slot for pairs completing off the publish edge.
  logic                  r_pend_valid;
  logic [DATA_WIDTH-1:0] r_pend_d0;
  logic [DATA_WIDTH-1:0] r_pend_d1;
  logic                  r_pend_v1;

  logic                  r_phase_f;
  logic [DATA_WIDTH-1:0] r_data_0;
  logic [DATA_WIDTH-1:0] r_data_1;
  logic                  r_valid_0;
  logic                  r_valid_1;
  logic                  r_overflow;

  // phase_f high before an edge marks that edge as a publish edge.
  logic                  w_publish;
  assign w_publish = r_phase_f;

  // Collector state, hold register and idle counter.
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      r_state    <= ST_EMPTY;
      r_hold0    <= '0;
      r_idle_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold0    <= w_hold0_nxt;
      r_idle_cnt <= w_idle_cnt_nxt;
    end
  end

  // Next collector state; pair completion by partner byte or by idle flush.
  // A valid byte on the final idle edge wins over the flush.
  always_comb begin
    w_state_nxt    = r_state;
    w_hold0_nxt    = r_hold0;
    w_idle_cnt_nxt = '0;
    w_pair_done    = 1'b0;
    w_pair_d0      = r_hold0;
    w_pair_d1      = '0;
    w_pair_v1      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (valid_in) begin
          w_hold0_nxt = data_in;
          w_state_nxt = ST_HALF;
        end
      end
      ST_HALF: begin
        if (valid_in) begin
          w_pair_done = 1'b1;
          w_pair_d1   = data_in;
          w_pair_v1   = 1'b1;
          w_state_nxt = ST_EMPTY;
        end else if (r_idle_cnt == IDLE_LAST) begin
          w_pair_done = 1'b1;
          w_state_nxt = ST_EMPTY;
        end else begin
          w_idle_cnt_nxt = r_idle_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  // Phase marker, pending slot, lane outputs and overflow checker.
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      r_phase_f    <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_d0    <= '0;
      r_pend_d1    <= '0;
      r_pend_v1    <= 1'b0;
      r_data_0     <= '0;
      r_data_1     <= '0;
      r_valid_0    <= 1'b0;
      r_valid_1    <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_phase_f <= ~r_phase_f;
      if (w_publish) begin
        if (r_pend_valid) begin
          // Older pair goes out first; a same-edge pair takes its slot.
          r_data_0     <= r_pend_d0;
          r_data_1     <= r_pend_d1;
          r_valid_0    <= 1'b1;
          r_valid_1    <= r_pend_v1;
          r_pend_valid <= w_pair_done;
          if (w_pair_done) begin
            r_pend_d0 <= w_pair_d0;
            r_pend_d1 <= w_pair_d1;
            r_pend_v1 <= w_pair_v1;
          end
        end else if (w_pair_done) begin
          r_data_0  <= w_pair_d0;
          r_data_1  <= w_pair_d1;
          r_valid_0 <= 1'b1;
          r_valid_1 <= w_pair_v1;
        end else begin
          r_valid_0 <= 1'b0;
          r_valid_1 <= 1'b0;
        end
      end else if (w_pair_done) begin
        if (r_pend_valid) begin
          r_overflow <= 1'b1;
        end else begin
          r_pend_valid <= 1'b1;
          r_pend_d0    <= w_pair_d0;
          r_pend_d1    <= w_pair_d1;
          r_pend_v1    <= w_pair_v1;
        end
      end
    end
  end

  assign data_stripe_0  = r_data_0;
  assign data_stripe_1  = r_data_1;
  assign valid_stripe_0 = r_valid_0;
  assign valid_stripe_1 = r_valid_1;
  assign phase_f        = r_phase_f;
  assign overflow_err   = r_overflow;

endmodule
